// File: rtl/instr_dispatch_queue.sv
// ---------------------------------------------------------------------------
// instr_dispatch_queue
//
// Instruction fetch / queue / dispatch front end for the Tomasulo datapath.
// The block fetches from a synchronous instruction ROM into a DEPTH-entry
// in-order FIFO. It decodes the head entry and hands it to the add/sub or
// mul/div reservation station when that station has room. Heads with an
// illegal opcode (1xx) are retired without dispatch.
//
// Fetch is throttled by credit. A fetch is only issued when the words already
// queued plus the word in flight leave a free slot, so a returning ROM word
// always has somewhere to go.
//
// Ports
//   Clock       in   single clock, rising edge
//   Clear       in   synchronous active-high reset
//   pc_load     in   redirect PC to pc_target and flush queue / in-flight word
//   pc_target   in   [PCW]  redirect target
//   imem_en     out  ROM read strobe
//   imem_addr   out  [PCW]  ROM address (current PC)
//   imem_data   in   [IW]   ROM data, valid the cycle after imem_en
//   rs_as_full  in   add/sub reservation station full
//   rs_md_full  in   mul/div reservation station full
//   disp_valid  out  head dispatched at this edge
//   disp_unit   out  0 = add/sub RS, 1 = mul/div RS
//   disp_instr  out  [IW]   raw head instruction
//   disp_op     out  [3]    head opcode
//   disp_rd     out  [RW]   head destination register
//   disp_rs     out  [RW]   head source register
//   illegal     out  head has an illegal opcode and is discarded at this edge
//   q_count     out  [CW]   queue occupancy
// ---------------------------------------------------------------------------
module instr_dispatch_queue #(
  parameter int IW    = 9,
  parameter int RW    = 3,
  parameter int PCW   = 6,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic           pc_load,
  input  logic [PCW-1:0] pc_target,
  output logic           imem_en,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  input  logic           rs_as_full,
  input  logic           rs_md_full,
  output logic           disp_valid,
  output logic           disp_unit,
  output logic [IW-1:0]  disp_instr,
  output logic [2:0]     disp_op,
  output logic [RW-1:0]  disp_rd,
  output logic [RW-1:0]  disp_rs,
  output logic           illegal,
  output logic [CW-1:0]  q_count
);

  localparam int AW = $clog2(DEPTH);

  // Opcode classification: bit 2 marks illegal, bit 1 selects mul/div unit.
  function automatic logic op_is_illegal(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_unit(input logic [2:0] op);
    return op[1];
  endfunction

  logic [PCW-1:0] pc_p0;
  logic           vld_p1;
  logic [IW-1:0]  q_mem [DEPTH];
  logic [AW-1:0]  head_ptr;
  logic [AW-1:0]  tail_ptr;
  logic [CW-1:0]  count;

  logic           nonempty;
  logic           blocked;
  logic           push;
  logic           pop;
  logic [CW:0]    occupancy;
  logic [IW-1:0]  head_instr;

  assign head_instr = q_mem[head_ptr];
  assign nonempty   = (count != '0);

  // Queued words plus the in-flight word must leave a slot free; a pop in
  // this same cycle is deliberately not counted as credit.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign imem_en    = !Clear && !pc_load && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr  = Clear ? '0 : pc_p0;

  assign disp_instr = head_instr;
  assign disp_op    = head_instr[IW-1 -: 3];
  assign disp_rd    = head_instr[2*RW-1 -: RW];
  assign disp_rs    = head_instr[RW-1:0];
  assign disp_unit  = op_unit(disp_op);

  assign blocked    = disp_unit ? rs_md_full : rs_as_full;
  assign disp_valid = !Clear && !pc_load && nonempty && !op_is_illegal(disp_op) && !blocked;
  assign illegal    = !Clear && !pc_load && nonempty && op_is_illegal(disp_op);

  // A word returning in a redirect or reset cycle belongs to the old stream.
  assign push       = vld_p1 && !pc_load && !Clear;
  assign pop        = disp_valid || illegal;

  assign q_count    = count;

  // Stage p0 -> p1: PC / fetch issue and queue control.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      pc_p0    <= '0;
      vld_p1   <= 1'b0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (pc_load) begin
      pc_p0    <= pc_target;
      vld_p1   <= 1'b0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (imem_en) pc_p0 <= pc_p0 + 1'b1;
      vld_p1 <= imem_en;
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1 -> queue: ROM word capture (storage needs no reset).
  always_ff @(posedge Clock) begin
    if (push) q_mem[tail_ptr] <= imem_data;
  end

endmodule
